// File: rtl/onehot_seq_pkg.sv
// Shared definitions for the one-hot sequence encoder.
//   state_e        : monitor FSM encoding (SEARCH = hunting for lock, TRACK = locked)
//   OH_W_DEF       : default one-hot input width
//   BIN_W_DEF      : default binary output width
package onehot_seq_pkg;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_TRACK  = 1'b1
  } state_e;

  localparam int OH_W_DEF  = 8;
  localparam int BIN_W_DEF = 3;

endpackage : onehot_seq_pkg

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary encoder.
//   onehot_i : OH_W-bit code word
//   bin_o    : index of the set bit (only meaningful when valid_o is high)
//   valid_o  : high when exactly one bit of onehot_i is set
module onehot_to_bin
  import onehot_seq_pkg::*;
#(
  parameter int OH_W  = OH_W_DEF,
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic [OH_W-1:0]  onehot_i,
  output logic [BIN_W-1:0] bin_o,
  output logic             valid_o
);

  // Clearing the lowest set bit leaves zero only for a power of two.
  logic [OH_W-1:0] lowest_cleared;
  assign lowest_cleared = onehot_i & (onehot_i - OH_W'(1));
  assign valid_o        = (onehot_i != '0) && (lowest_cleared == '0);

  // OR of the indices of all set bits; exact whenever the word is one-hot.
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < OH_W; i++) begin
      if (onehot_i[i]) begin
        bin_o = bin_o | BIN_W'(i);
      end
    end
  end

endmodule : onehot_to_bin

// File: rtl/onehot_seq_encoder.sv
// One-hot sequence monitor and binary re-encoder.
// Re-encodes a decoder's one-hot word to binary, checks successive valid codes
// count up by one (mod 2**BIN_W), locks after LOCK_LEN in-sequence samples and
// flags/counts malformed or out-of-order codes.
//   clock        : rising-edge clock
//   reset        : synchronous active-high reset, overrides all inputs
//   enable       : low freezes all state and suppresses pulses
//   sample_valid : onehot_in is taken this cycle (when enable is high)
//   onehot_in    : one-hot code word
//   bin_out      : binary index of the last valid code
//   bin_valid    : 1-cycle pulse, bin_out updated from a valid code
//   onehot_err   : 1-cycle pulse, accepted word was not exactly one-hot
//   seq_err      : 1-cycle pulse, valid code out of sequence while locked
//   locked       : high while in TRACK
//   err_count    : saturating count of onehot_err + seq_err events
module onehot_seq_encoder
  import onehot_seq_pkg::*;
#(
  parameter int OH_W     = OH_W_DEF,
  parameter int BIN_W    = BIN_W_DEF,
  parameter int LOCK_LEN = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sample_valid,
  input  logic [OH_W-1:0]  onehot_in,
  output logic [BIN_W-1:0] bin_out,
  output logic             bin_valid,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int RUN_W = $clog2(LOCK_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_LEN);

  logic [BIN_W-1:0] idx;
  logic             code_ok;

  onehot_to_bin #(
    .OH_W (OH_W),
    .BIN_W(BIN_W)
  ) u_enc (
    .onehot_i(onehot_in),
    .bin_o   (idx),
    .valid_o (code_ok)
  );

  state_e           state_q,      state_d;
  logic [RUN_W-1:0] run_q,        run_d;
  logic [BIN_W-1:0] expected_q,   expected_d;
  logic [BIN_W-1:0] bin_q,        bin_d;
  logic             bin_valid_q,  bin_valid_d;
  logic             oh_err_q,     oh_err_d;
  logic             seq_err_q,    seq_err_d;
  logic [ERR_W-1:0] err_q,        err_d;

  logic accept;
  logic err_event;
  assign accept = enable && sample_valid;

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    expected_d  = expected_q;
    bin_d       = bin_q;
    bin_valid_d = 1'b0;
    oh_err_d    = 1'b0;
    seq_err_d   = 1'b0;
    err_event   = 1'b0;

    if (accept) begin
      if (!code_ok) begin
        oh_err_d  = 1'b1;
        err_event = 1'b1;
        run_d     = '0;
        state_d   = ST_SEARCH;
      end else begin
        bin_d       = idx;
        bin_valid_d = 1'b1;
        expected_d  = idx + BIN_W'(1);
        unique case (state_q)
          ST_SEARCH: begin
            if ((run_q != '0) && (idx == expected_q)) begin
              run_d = (run_q == RUN_LOCK) ? run_q : run_q + RUN_W'(1);
            end else begin
              run_d = RUN_W'(1);
            end
            if (run_d == RUN_LOCK) begin
              state_d = ST_TRACK;
            end
          end
          ST_TRACK: begin
            if (idx != expected_q) begin
              seq_err_d = 1'b1;
              err_event = 1'b1;
              run_d     = RUN_W'(1);
              state_d   = ST_SEARCH;
            end
          end
          default: state_d = ST_SEARCH;
        endcase
      end
    end

    err_d = err_q;
    if (err_event && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_SEARCH;
      run_q       <= '0;
      expected_q  <= '0;
      bin_q       <= '0;
      bin_valid_q <= 1'b0;
      oh_err_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      expected_q  <= expected_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      oh_err_q    <= oh_err_d;
      seq_err_q   <= seq_err_d;
      err_q       <= err_d;
    end
  end

  assign bin_out    = bin_q;
  assign bin_valid  = bin_valid_q;
  assign onehot_err = oh_err_q;
  assign seq_err    = seq_err_q;
  assign locked     = (state_q == ST_TRACK);
  assign err_count  = err_q;

endmodule : onehot_seq_encoder

// File: tb/tb_onehot_seq_encoder.sv
// Directed bench for onehot_seq_encoder. A second instance with ERR_W=2 shares
// the stimulus and is used for the error-counter saturation check.
module tb_onehot_seq_encoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       sample_valid;
  logic [7:0] onehot_in;

  logic [2:0] bin_out,    s_bin_out;
  logic       bin_valid,  s_bin_valid;
  logic       onehot_err, s_onehot_err;
  logic       seq_err,    s_seq_err;
  logic       locked,     s_locked;
  logic [7:0] err_count;
  logic [1:0] s_err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  onehot_seq_encoder #(.OH_W(8), .BIN_W(3), .LOCK_LEN(2), .ERR_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .sample_valid(sample_valid),
    .onehot_in   (onehot_in),
    .bin_out     (bin_out),
    .bin_valid   (bin_valid),
    .onehot_err  (onehot_err),
    .seq_err     (seq_err),
    .locked      (locked),
    .err_count   (err_count)
  );

  onehot_seq_encoder #(.OH_W(8), .BIN_W(3), .LOCK_LEN(2), .ERR_W(2)) dut_sat (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .sample_valid(sample_valid),
    .onehot_in   (onehot_in),
    .bin_out     (s_bin_out),
    .bin_valid   (s_bin_valid),
    .onehot_err  (s_onehot_err),
    .seq_err     (s_seq_err),
    .locked      (s_locked),
    .err_count   (s_err_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; outputs settle 1 ns after the next rising edge.
  task automatic step(input logic rst, input logic en, input logic sv, input logic [7:0] oh);
    @(negedge clock);
    reset        = rst;
    enable       = en;
    sample_valid = sv;
    onehot_in    = oh;
    @(posedge clock);
    #1;
    $display("t=%0t rst=%0b en=%0b sv=%0b oh=%02h -> bin=%0d bv=%0b ohe=%0b se=%0b lk=%0b ec=%0d sec=%0d",
             $time, rst, en, sv, oh, bin_out, bin_valid, onehot_err, seq_err, locked,
             err_count, s_err_count);
  endtask

  // Compact output check: bin_out, bin_valid, onehot_err, seq_err, locked, err_count.
  task automatic check_all(input string tag, input int b, input int bv, input int ohe,
                           input int se, input int lk, input int ec);
    check_eq({tag, ".bin"},  32'(bin_out),    32'(b));
    check_eq({tag, ".bv"},   32'(bin_valid),  32'(bv));
    check_eq({tag, ".ohe"},  32'(onehot_err), 32'(ohe));
    check_eq({tag, ".se"},   32'(seq_err),    32'(se));
    check_eq({tag, ".lk"},   32'(locked),     32'(lk));
    check_eq({tag, ".ec"},   32'(err_count),  32'(ec));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; sample_valid = 1'b1; onehot_in = 8'h01;

    // 1: reset dominates an active valid sample
    step(1, 1, 1, 8'h01);
    step(1, 1, 1, 8'h01);
    check_all("rst", 0, 0, 0, 0, 0, 0);
    check_eq("rst.sat_ec", 32'(s_err_count), 32'd0);

    // 2: two in-sequence samples lock
    step(0, 1, 1, 8'h01); check_all("acq0", 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 8'h02); check_all("acq1", 1, 1, 0, 0, 1, 0);

    // 3: keep counting through the 7 -> 0 wrap
    step(0, 1, 1, 8'h04); check_all("cnt2", 2, 1, 0, 0, 1, 0);
    step(0, 1, 1, 8'h08); check_all("cnt3", 3, 1, 0, 0, 1, 0);
    step(0, 1, 1, 8'h10); check_all("cnt4", 4, 1, 0, 0, 1, 0);
    step(0, 1, 1, 8'h20); check_all("cnt5", 5, 1, 0, 0, 1, 0);
    step(0, 1, 1, 8'h40); check_all("cnt6", 6, 1, 0, 0, 1, 0);
    step(0, 1, 1, 8'h80); check_all("cnt7", 7, 1, 0, 0, 1, 0);
    step(0, 1, 1, 8'h01); check_all("wrap0", 0, 1, 0, 0, 1, 0);

    // 4: locked at 3, skip to 5 -> seq_err, unlock; 6 relocks
    step(0, 1, 1, 8'h02); check_all("s1", 1, 1, 0, 0, 1, 0);
    step(0, 1, 1, 8'h04); check_all("s2", 2, 1, 0, 0, 1, 0);
    step(0, 1, 1, 8'h08); check_all("s3", 3, 1, 0, 0, 1, 0);
    step(0, 1, 1, 8'h20); check_all("skip5", 5, 1, 0, 1, 0, 1);
    step(0, 1, 1, 8'h40); check_all("relock6", 6, 1, 0, 0, 1, 1);
    step(0, 1, 0, 8'h80); check_all("idle", 6, 0, 0, 0, 1, 1);

    // 5: malformed words; saturation on the ERR_W=2 instance
    step(0, 1, 1, 8'h00); check_all("zero", 6, 0, 1, 0, 0, 2);
    step(0, 1, 1, 8'h11); check_all("two", 6, 0, 1, 0, 0, 3);
    check_eq("sat3", 32'(s_err_count), 32'd3);
    step(0, 1, 1, 8'h03); check_all("inv3", 6, 0, 1, 0, 0, 4);
    step(0, 1, 1, 8'hFF); check_all("inv4", 6, 0, 1, 0, 0, 5);
    step(0, 1, 1, 8'h00); check_all("inv5", 6, 0, 1, 0, 0, 6);
    check_eq("sat_hold", 32'(s_err_count), 32'd3);
    check_eq("sat_flag", 32'(s_onehot_err), 32'd1);

    // 6: relock (expected still 7), then freeze with enable low
    step(0, 1, 1, 8'h80); check_all("rl7", 7, 1, 0, 0, 0, 6);
    step(0, 1, 1, 8'h01); check_all("rl0", 0, 1, 0, 0, 1, 6);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 8'h04); check_all("frz", 0, 0, 0, 0, 1, 6);
    end
    step(0, 1, 1, 8'h02); check_all("unfrz", 1, 1, 0, 0, 1, 6);

    // reset while locked clears lock and error count
    step(1, 1, 1, 8'h04); check_all("rst2", 0, 0, 0, 0, 0, 0);
    check_eq("rst2.sat_ec", 32'(s_err_count), 32'd0);
    step(0, 1, 1, 8'h08); check_all("post", 3, 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_onehot_seq_encoder
